// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: drives one digit per slot with an
// optional all-dark gap between slots; every output comes straight from a register.
`timescale 1ns/1ps
module disp_scan_ctrl #(
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] en,
  output logic [3:0] anode,
  output logic [7:0] cathode,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      idx_reg, idx_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      anode_reg, anode_next;
  logic [7:0]      cathode_reg, cathode_next;
  logic            tick_reg, tick_next;

  logic            enter_drive;
  logic [1:0]      entry_idx;
  logic [3:0][7:0] in_bus;
  logic [3:0]      sel_anode [4];
  logic [7:0]      sel_cath  [4];

  assign in_bus = {in3, in2, in1, in0};

  // Per-digit slot-entry values; a disabled digit stays dark but keeps its slot.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign sel_anode[gi] = en[gi] ? ~(4'b0001 << gi) : 4'hF;
      assign sel_cath[gi]  = en[gi] ? in_bus[gi] : 8'hFF;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= BLANK;
      idx_reg     <= 2'd0;
      cnt_reg     <= '0;
      anode_reg   <= 4'hF;
      cathode_reg <= 8'hFF;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      anode_reg   <= anode_next;
      cathode_reg <= cathode_next;
      tick_reg    <= tick_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    anode_next   = anode_reg;
    cathode_next = cathode_reg;
    tick_next    = 1'b0;
    enter_drive  = 1'b0;
    entry_idx    = idx_reg;

    case (state_reg)
      BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_reg == BLANK_LAST) begin
          enter_drive = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_reg == ON_LAST) begin
          cnt_next = '0;
          idx_next = idx_reg + 2'd1;
          if (BLANK_CYCLES > 0) begin
            state_next   = BLANK;
            anode_next   = 4'hF;
            cathode_next = 8'hFF;
          end else begin
            // No gap: go straight into the next digit's slot.
            enter_drive = 1'b1;
            entry_idx   = idx_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase

    // Inputs are captured only here; they are held for the whole slot.
    if (enter_drive) begin
      state_next   = DRIVE;
      anode_next   = sel_anode[entry_idx];
      cathode_next = sel_cath[entry_idx];
      tick_next    = (entry_idx == 2'd0);
    end
  end

  assign anode      = anode_reg;
  assign cathode    = cathode_reg;
  assign frame_tick = tick_reg;

endmodule
